multi_ch_window_discriminator: RTL and testbench

//  Parametrised N-channel successor to the single-channel DAC threshold/window FSM.

---
 rtl/disc_pkg.sv | 14 +
 rtl/disc_channel_step.sv | 82 ++++++++
 rtl/multi_ch_window_discriminator.sv | 133 +++++++++++++
 tb/tb_multi_ch_window_discriminator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/disc_pkg.sv
// Shared types and constants for the multi-channel window discriminator.
package disc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        WIN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int CH_IDX_W  = 6;
    localparam int HIT_CNT_W = 16;

endpackage

// File: rtl/disc_channel_step.sv
// Combinational next-state logic for one channel; the top time-shares a single
// instance across all channels by feeding it the selected channel's stored state.
module disc_channel_step
    import disc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int WIN_W  = 16
) (
    input  state_t                    state_cur,
    input  logic [WIN_W-1:0]          count_cur,
    input  logic                      over_prev,
    input  logic                      thresh_cur,
    input  logic signed [DATA_W-1:0]  sample,
    input  logic signed [DATA_W-1:0]  thrsh,
    input  logic                      pol,
    input  logic                      fsm_mode,
    input  logic                      edge_type,
    input  logic [WIN_W-1:0]          win_start,
    input  logic [WIN_W-1:0]          win_stop,
    input  logic [WIN_W-1:0]          stop_max,
    output state_t                    state_nxt,
    output logic [WIN_W-1:0]          count_nxt,
    output logic                      over,
    output logic                      thresh_nxt,
    output logic                      window_nxt,
    output logic                      hit
);

    logic              trig;
    logic [WIN_W-1:0]  count_inc;
    logic [WIN_W-1:0]  offset;

    // The trigger sample itself is offset 0, so a window starting at 0 can hit on it.
    always_comb begin
        over       = pol ? (sample > thrsh) : (sample < thrsh);
        trig       = edge_type ? (over_prev & ~over) : (over & ~over_prev);
        count_inc  = (count_cur == '1) ? count_cur : count_cur + 1'b1;
        offset     = '0;
        state_nxt  = state_cur;
        count_nxt  = count_cur;
        thresh_nxt = thresh_cur;
        hit        = 1'b0;

        if (!fsm_mode) begin
            state_nxt  = IDLE;
            count_nxt  = '0;
            thresh_nxt = over;
        end else if (state_cur == IDLE && !trig) begin
            state_nxt  = IDLE;
            count_nxt  = '0;
            thresh_nxt = 1'b0;
        end else begin
            offset    = (state_cur == IDLE) ? '0 : count_inc;
            count_nxt = offset;
            if (state_cur != IDLE && offset >= stop_max) begin
                state_nxt  = IDLE;
                count_nxt  = '0;
                thresh_nxt = 1'b0;
            end else if (state_cur == HOLD) begin
                state_nxt = HOLD;
            end else if (offset > win_stop) begin
                state_nxt  = HOLD;
                thresh_nxt = 1'b0;
            end else if (offset >= win_start) begin
                if (over) begin
                    hit        = 1'b1;
                    state_nxt  = HOLD;
                    thresh_nxt = 1'b1;
                end else begin
                    state_nxt  = WIN;
                    thresh_nxt = 1'b0;
                end
            end else begin
                state_nxt  = WAIT;
                thresh_nxt = 1'b0;
            end
        end

        window_nxt = (state_nxt == WIN);
    end

endmodule

// File: rtl/multi_ch_window_discriminator.sv
// N-channel threshold/window discriminator over time-multiplexed samples.
// Optional per-channel hit counters are built when DISC_HIT_COUNT_EN is defined.
module multi_ch_window_discriminator
    import disc_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 16,
    parameter int WIN_W  = 16
) (
    input  logic                      dataclk,
    input  logic                      reset,
    input  logic                      sample_valid,
    input  logic [CH_IDX_W-1:0]       ch_idx,
    input  logic [DATA_W-1:0]         sample,
    input  logic [N_CH*DATA_W-1:0]    thrsh,
    input  logic [N_CH-1:0]           thrsh_pol,
    input  logic                      fsm_mode,
    input  logic                      edge_type,
    input  logic [WIN_W-1:0]          win_start,
    input  logic [WIN_W-1:0]          win_stop,
    input  logic [WIN_W-1:0]          stop_max,
    output logic [N_CH-1:0]           thresh_out,
    output logic [N_CH-1:0]           window_state,
    output logic                      hit_valid,
    output logic [CH_IDX_W-1:0]       hit_ch
`ifdef DISC_HIT_COUNT_EN
   ,input  logic [CH_IDX_W-1:0]       cnt_sel,
    input  logic                      cnt_clr,
    output logic [HIT_CNT_W-1:0]      hit_cnt
`endif
);

    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_IDX_W:0] N_CH_L = (CH_IDX_W + 1)'(N_CH);

    state_t             state_q   [N_CH];
    logic [WIN_W-1:0]   count_q   [N_CH];
    logic [N_CH-1:0]    over_prev_q;

    logic               ch_ok;
    logic               strobe;
    logic [SEL_W-1:0]   ch_sel;

    state_t             state_nxt;
    logic [WIN_W-1:0]   count_nxt;
    logic               over;
    logic               thresh_nxt;
    logic               window_nxt;
    logic               hit;

    assign ch_ok  = ({1'b0, ch_idx} < N_CH_L);
    assign strobe = sample_valid & ch_ok;
    assign ch_sel = ch_ok ? ch_idx[SEL_W-1:0] : '0;

    disc_channel_step #(
        .DATA_W (DATA_W),
        .WIN_W  (WIN_W)
    ) u_step (
        .state_cur  (state_q[ch_sel]),
        .count_cur  (count_q[ch_sel]),
        .over_prev  (over_prev_q[ch_sel]),
        .thresh_cur (thresh_out[ch_sel]),
        .sample     (sample),
        .thrsh      (thrsh[ch_sel*DATA_W +: DATA_W]),
        .pol        (thrsh_pol[ch_sel]),
        .fsm_mode   (fsm_mode),
        .edge_type  (edge_type),
        .win_start  (win_start),
        .win_stop   (win_stop),
        .stop_max   (stop_max),
        .state_nxt  (state_nxt),
        .count_nxt  (count_nxt),
        .over       (over),
        .thresh_nxt (thresh_nxt),
        .window_nxt (window_nxt),
        .hit        (hit)
    );

    // Only the strobed channel's slot is written; every other channel holds.
    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                count_q[i] <= '0;
            end
            over_prev_q  <= '0;
            thresh_out   <= '0;
            window_state <= '0;
            hit_valid    <= 1'b0;
            hit_ch       <= '0;
        end else begin
            hit_valid <= 1'b0;
            if (strobe) begin
                state_q[ch_sel]      <= state_nxt;
                count_q[ch_sel]      <= count_nxt;
                over_prev_q[ch_sel]  <= over;
                thresh_out[ch_sel]   <= thresh_nxt;
                window_state[ch_sel] <= window_nxt;
                if (hit) begin
                    hit_valid <= 1'b1;
                    hit_ch    <= ch_idx;
                end
            end
        end
    end

`ifdef DISC_HIT_COUNT_EN
    logic [HIT_CNT_W-1:0] hit_cnt_q [N_CH];
    logic                 cnt_ok;

    assign cnt_ok = ({1'b0, cnt_sel} < N_CH_L);

    // Clear wins over a coincident hit; readback is one cycle behind cnt_sel.
    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                hit_cnt_q[i] <= '0;
            end
            hit_cnt <= '0;
        end else begin
            if (cnt_clr) begin
                for (int i = 0; i < N_CH; i++) begin
                    hit_cnt_q[i] <= '0;
                end
            end else if (strobe && hit && hit_cnt_q[ch_sel] != '1) begin
                hit_cnt_q[ch_sel] <= hit_cnt_q[ch_sel] + 1'b1;
            end
            hit_cnt <= cnt_ok ? hit_cnt_q[cnt_sel[SEL_W-1:0]] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_multi_ch_window_discriminator.sv
// Directed scoreboard bench for multi_ch_window_discriminator (default build, N_CH=4).
module tb_multi_ch_window_discriminator;

    localparam int N_CH   = 4;
    localparam int DATA_W = 16;
    localparam int WIN_W  = 16;

    logic                    dataclk = 1'b0;
    logic                    reset = 1'b1;
    logic                    sample_valid = 1'b0;
    logic [5:0]              ch_idx = '0;
    logic [DATA_W-1:0]       sample = '0;
    logic [N_CH*DATA_W-1:0]  thrsh = {16'd100, 16'd105, 16'd100, 16'd100};
    logic [N_CH-1:0]         thrsh_pol = 4'b1101;
    logic                    fsm_mode = 1'b0;
    logic                    edge_type = 1'b0;
    logic [WIN_W-1:0]        win_start = '0;
    logic [WIN_W-1:0]        win_stop = '0;
    logic [WIN_W-1:0]        stop_max = '0;
    logic [N_CH-1:0]         thresh_out;
    logic [N_CH-1:0]         window_state;
    logic                    hit_valid;
    logic [5:0]              hit_ch;

    typedef struct packed {
        logic [3:0] thresh;
        logic [3:0] win;
        logic       hv;
        logic [5:0] hch;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    failures = 0;

    multi_ch_window_discriminator #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .WIN_W  (WIN_W)
    ) dut (
        .dataclk      (dataclk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .ch_idx       (ch_idx),
        .sample       (sample),
        .thrsh        (thrsh),
        .thrsh_pol    (thrsh_pol),
        .fsm_mode     (fsm_mode),
        .edge_type    (edge_type),
        .win_start    (win_start),
        .win_stop     (win_stop),
        .stop_max     (stop_max),
        .thresh_out   (thresh_out),
        .window_state (window_state),
        .hit_valid    (hit_valid),
        .hit_ch       (hit_ch)
    );

    always #5 dataclk = ~dataclk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drain_scoreboard();
        exp_t  e;
        string t;
        if (sb_q.size() == 0) begin
            check_output("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check_output({t, ".thresh_out"}, 32'(thresh_out), 32'(e.thresh));
            check_output({t, ".window_state"}, 32'(window_state), 32'(e.win));
            check_output({t, ".hit_valid"}, 32'(hit_valid), 32'(e.hv));
            check_output({t, ".hit_ch"}, 32'(hit_ch), 32'(e.hch));
        end
    endtask

    task automatic apply_stimulus(input logic vld, input logic [5:0] ch, input logic [15:0] smp,
                                  input logic [3:0] et, input logic [3:0] ew,
                                  input logic ehv, input logic [5:0] ehc, input string tag);
        exp_t e;
        @(negedge dataclk);
        sample_valid = vld;
        ch_idx       = ch;
        sample       = smp;
        e.thresh = et;
        e.win    = ew;
        e.hv     = ehv;
        e.hch    = ehc;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge dataclk);
        #1;
        sample_valid = 1'b0;
        drain_scoreboard();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        #1;
        check_output("rst.thresh_out", 32'(thresh_out), 32'd0);
        check_output("rst.window_state", 32'(window_state), 32'd0);
        check_output("rst.hit_valid", 32'(hit_valid), 32'd0);
        check_output("rst.hit_ch", 32'(hit_ch), 32'd0);
        @(negedge dataclk);
        reset = 1'b1;

        // raw threshold mode, ch1 uses inverted polarity
        apply_stimulus(1, 2, 16'd200, 4'b0100, 4'b0000, 0, 6'd0, "raw_ch2_over");
        apply_stimulus(1, 2, 16'd105, 4'b0000, 4'b0000, 0, 6'd0, "raw_ch2_equal");
        apply_stimulus(1, 2, 16'd106, 4'b0100, 4'b0000, 0, 6'd0, "raw_ch2_just_over");
        apply_stimulus(1, 1, 16'd50,  4'b0110, 4'b0000, 0, 6'd0, "raw_ch1_pol0");
        apply_stimulus(1, 5, 16'd200, 4'b0110, 4'b0000, 0, 6'd0, "raw_bad_ch");

        fsm_mode  = 1'b1;
        thrsh_pol = 4'b1111;
        win_start = 16'd0;
        win_stop  = 16'd3;
        stop_max  = 16'd3;
        apply_stimulus(1, 0, 16'd50,  4'b0110, 4'b0000, 0, 6'd0, "win0_below");
        apply_stimulus(1, 0, 16'd200, 4'b0111, 4'b0000, 1, 6'd0, "win0_hit");
        apply_stimulus(1, 0, 16'd0,   4'b0111, 4'b0000, 0, 6'd0, "win0_hold1");
        apply_stimulus(1, 0, 16'd150, 4'b0111, 4'b0000, 0, 6'd0, "win0_hold2");
        apply_stimulus(1, 0, 16'd150, 4'b0110, 4'b0000, 0, 6'd0, "win0_stopmax");
        apply_stimulus(1, 0, 16'd150, 4'b0110, 4'b0000, 0, 6'd0, "win0_no_retrig");
        apply_stimulus(1, 0, 16'd0,   4'b0110, 4'b0000, 0, 6'd0, "win0_fall");

        win_start = 16'd2;
        win_stop  = 16'd3;
        stop_max  = 16'd10;
        apply_stimulus(1, 3, 16'd200, 4'b0110, 4'b0000, 0, 6'd0, "wait_trig");
        apply_stimulus(1, 3, 16'd200, 4'b0110, 4'b0000, 0, 6'd0, "wait_early_over");
        apply_stimulus(1, 3, 16'd200, 4'b1110, 4'b0000, 1, 6'd3, "wait_hit_at2");
        for (int k = 3; k <= 9; k++) begin
            apply_stimulus(1, 3, 16'd50, 4'b1110, 4'b0000, 0, 6'd3, "wait_hold");
        end
        apply_stimulus(1, 3, 16'd50, 4'b0110, 4'b0000, 0, 6'd3, "wait_idle_at_max");

        // round robin, only ch1 crosses
        win_start = 16'd1;
        win_stop  = 16'd2;
        stop_max  = 16'd6;
        apply_stimulus(1, 0, 16'd50,  4'b0110, 4'b0000, 0, 6'd3, "rr1_ch0");
        apply_stimulus(1, 1, 16'd50,  4'b0100, 4'b0000, 0, 6'd3, "rr1_ch1");
        apply_stimulus(1, 2, 16'd50,  4'b0000, 4'b0000, 0, 6'd3, "rr1_ch2");
        apply_stimulus(1, 3, 16'd50,  4'b0000, 4'b0000, 0, 6'd3, "rr1_ch3");
        apply_stimulus(1, 0, 16'd50,  4'b0000, 4'b0000, 0, 6'd3, "rr2_ch0");
        apply_stimulus(1, 1, 16'd200, 4'b0000, 4'b0000, 0, 6'd3, "rr2_ch1_trig");
        apply_stimulus(1, 2, 16'd50,  4'b0000, 4'b0000, 0, 6'd3, "rr2_ch2");
        apply_stimulus(1, 3, 16'd50,  4'b0000, 4'b0000, 0, 6'd3, "rr2_ch3");
        apply_stimulus(1, 0, 16'd60,  4'b0000, 4'b0000, 0, 6'd3, "rr3_ch0");
        apply_stimulus(1, 1, 16'd50,  4'b0000, 4'b0010, 0, 6'd3, "rr3_ch1_win");
        apply_stimulus(1, 2, 16'd70,  4'b0000, 4'b0010, 0, 6'd3, "rr3_ch2");
        apply_stimulus(1, 3, 16'd80,  4'b0000, 4'b0010, 0, 6'd3, "rr3_ch3");
        apply_stimulus(1, 0, 16'd50,  4'b0000, 4'b0010, 0, 6'd3, "rr4_ch0");
        apply_stimulus(1, 1, 16'd200, 4'b0010, 4'b0000, 1, 6'd1, "rr4_ch1_hit");
        apply_stimulus(1, 2, 16'd50,  4'b0010, 4'b0000, 0, 6'd1, "rr4_ch2");
        apply_stimulus(1, 3, 16'd50,  4'b0010, 4'b0000, 0, 6'd1, "rr4_ch3");

        // empty window: stop before start
        win_start = 16'd4;
        win_stop  = 16'd1;
        stop_max  = 16'd5;
        for (int k = 0; k <= 4; k++) begin
            apply_stimulus(1, 2, 16'd200, 4'b0010, 4'b0000, 0, 6'd1, "empty_win");
        end
        apply_stimulus(1, 2, 16'd50, 4'b0010, 4'b0000, 0, 6'd1, "empty_idle");
        win_start = 16'd0;
        win_stop  = 16'd3;
        stop_max  = 16'd5;
        apply_stimulus(1, 2, 16'd200, 4'b0110, 4'b0000, 1, 6'd2, "empty_rearm_hit");

        edge_type = 1'b1;
        stop_max  = 16'd4;
        apply_stimulus(1, 0, 16'd200, 4'b0110, 4'b0000, 0, 6'd2, "fall_enter_no_trig");
        apply_stimulus(1, 0, 16'd50,  4'b0110, 4'b0001, 0, 6'd2, "fall_trig_win");
        apply_stimulus(1, 0, 16'd200, 4'b0111, 4'b0000, 1, 6'd0, "fall_hit");

        edge_type = 1'b0;
        stop_max  = 16'd0;
        apply_stimulus(1, 3, 16'd200, 4'b1111, 4'b0000, 1, 6'd3, "max0_hit");
        apply_stimulus(1, 3, 16'd200, 4'b0111, 4'b0000, 0, 6'd3, "max0_idle");

        fsm_mode = 1'b0;
        apply_stimulus(1, 1, 16'd50, 4'b0101, 4'b0000, 0, 6'd3, "mode0_force_idle");
        fsm_mode = 1'b1;
        stop_max = 16'd4;
        apply_stimulus(1, 1, 16'd200, 4'b0111, 4'b0000, 1, 6'd1, "mode1_rearm_hit");

        // async reset while ch3 sits in its window
        win_start = 16'd1;
        win_stop  = 16'd5;
        stop_max  = 16'd10;
        apply_stimulus(1, 3, 16'd50,  4'b0111, 4'b0000, 0, 6'd1, "rst_pre_low");
        apply_stimulus(1, 3, 16'd200, 4'b0111, 4'b0000, 0, 6'd1, "rst_pre_trig");
        apply_stimulus(1, 3, 16'd50,  4'b0111, 4'b1000, 0, 6'd1, "rst_pre_win");
        #2 reset = 1'b0;
        #1;
        check_output("rst_mid.thresh_out", 32'(thresh_out), 32'd0);
        check_output("rst_mid.window_state", 32'(window_state), 32'd0);
        check_output("rst_mid.hit_valid", 32'(hit_valid), 32'd0);
        check_output("rst_mid.hit_ch", 32'(hit_ch), 32'd0);
        repeat (2) @(negedge dataclk);
        reset = 1'b1;
        win_start = 16'd0;
        win_stop  = 16'd3;
        stop_max  = 16'd4;
        apply_stimulus(1, 3, 16'd200, 4'b1000, 4'b0000, 1, 6'd3, "rst_rearm_hit");
        apply_stimulus(0, 3, 16'd0,   4'b1000, 4'b0000, 0, 6'd3, "rst_pulse_end");

        check_output("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
